// File: rtl/fifo_wr_ctrl.sv
// Write-side pointer and flag controller for an asynchronous FIFO.
// Keeps the binary/Gray write pointer and synchronizes the read pointer into wCLK.
module fifo_wr_ctrl #(
  parameter int ADDR_WIDTH = 3,
  parameter int AF_MARGIN  = 2
) (
  input  logic                  wCLK,
  input  logic                  wRST,
  input  logic                  w_INC,
  input  logic [ADDR_WIDTH:0]   r_GPTR,
  input  logic                  w_OVF_CLR,
  output logic [ADDR_WIDTH-1:0] w_ADDR,
  output logic [ADDR_WIDTH:0]   w_GPTR,
  output logic                  w_FULL,
  output logic                  w_ALMOST_FULL,
  output logic [ADDR_WIDTH:0]   w_LEVEL,
  output logic                  w_OVF
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] AF_THRESH = (ADDR_WIDTH+1)'(DEPTH - AF_MARGIN);

  logic [ADDR_WIDTH:0] wbin;
  logic [ADDR_WIDTH:0] wbin_next;
  logic [ADDR_WIDTH:0] wgray_next;
  logic [ADDR_WIDTH:0] rq1;
  logic [ADDR_WIDTH:0] rq2;
  logic [ADDR_WIDTH:0] rbin;
  logic [ADDR_WIDTH:0] full_pattern;
  logic                accept;
  logic                full_next;

  always_comb begin
    accept       = w_INC && !w_FULL;
    wbin_next    = wbin + {{ADDR_WIDTH{1'b0}}, accept};
    wgray_next   = (wbin_next >> 1) ^ wbin_next;
    // Full when the write pointer has lapped the read pointer: top two Gray bits inverted.
    full_pattern = {~rq2[ADDR_WIDTH:ADDR_WIDTH-1], rq2[ADDR_WIDTH-2:0]};
    full_next    = (wgray_next == full_pattern);
    rbin         = '0;
    for (int i = 0; i <= ADDR_WIDTH; i++) begin
      rbin[i] = ^(rq2 >> i);
    end
  end

  always_ff @(posedge wCLK or negedge wRST) begin
    if (!wRST) begin
      wbin   <= '0;
      w_GPTR <= '0;
      w_FULL <= 1'b0;
    end else begin
      wbin   <= wbin_next;
      w_GPTR <= wgray_next;
      w_FULL <= full_next;
    end
  end

  always_ff @(posedge wCLK or negedge wRST) begin
    if (!wRST) begin
      rq1 <= '0;
      rq2 <= '0;
    end else begin
      rq1 <= r_GPTR;
      rq2 <= rq1;
    end
  end

  // Sticky overflow: a rejected write always wins over a clear in the same cycle.
  always_ff @(posedge wCLK or negedge wRST) begin
    if (!wRST) begin
      w_OVF <= 1'b0;
    end else if (w_INC && w_FULL) begin
      w_OVF <= 1'b1;
    end else if (w_OVF_CLR) begin
      w_OVF <= 1'b0;
    end
  end

  assign w_ADDR        = wbin[ADDR_WIDTH-1:0];
  assign w_LEVEL       = wbin - rbin;
  assign w_ALMOST_FULL = (w_LEVEL >= AF_THRESH);

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Directed self-checking bench for fifo_wr_ctrl at ADDR_WIDTH=3, AF_MARGIN=2.
module tb_fifo_wr_ctrl;

  logic       wCLK;
  logic       wRST;
  logic       w_INC;
  logic [3:0] r_GPTR;
  logic       w_OVF_CLR;
  logic [2:0] w_ADDR;
  logic [3:0] w_GPTR;
  logic       w_FULL;
  logic       w_ALMOST_FULL;
  logic [3:0] w_LEVEL;
  logic       w_OVF;

  int total_checks;
  int bad_checks;

  fifo_wr_ctrl #(.ADDR_WIDTH(3), .AF_MARGIN(2)) dut (
    .wCLK(wCLK),
    .wRST(wRST),
    .w_INC(w_INC),
    .r_GPTR(r_GPTR),
    .w_OVF_CLR(w_OVF_CLR),
    .w_ADDR(w_ADDR),
    .w_GPTR(w_GPTR),
    .w_FULL(w_FULL),
    .w_ALMOST_FULL(w_ALMOST_FULL),
    .w_LEVEL(w_LEVEL),
    .w_OVF(w_OVF)
  );

  initial wCLK = 1'b0;
  always #5 wCLK = ~wCLK;

  function automatic logic [3:0] gray(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total_checks++;
    if (observed !== expected) begin
      bad_checks++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Advance one edge and settle 1ns past it, away from the active edge.
  task automatic applyStimulus(input logic inc, input logic clr);
    w_INC     = inc;
    w_OVF_CLR = clr;
    @(posedge wCLK);
    #1;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_addr"}, 32'(w_ADDR), 0);
    checkOutput({tag, "_gptr"}, 32'(w_GPTR), 0);
    checkOutput({tag, "_full"}, 32'(w_FULL), 0);
    checkOutput({tag, "_af"}, 32'(w_ALMOST_FULL), 0);
    checkOutput({tag, "_level"}, 32'(w_LEVEL), 0);
    checkOutput({tag, "_ovf"}, 32'(w_OVF), 0);
  endtask

  initial begin
    logic [3:0] exp_wbin;
    logic [3:0] prev_gptr;
    total_checks = 0;
    bad_checks   = 0;

    // Reset with arbitrary inputs, before any clock edge
    wRST      = 1'b0;
    w_INC     = 1'b1;
    r_GPTR    = 4'b1010;
    w_OVF_CLR = 1'b1;
    #1;
    checkAllZero("reset_noclk");
    applyStimulus(1'b1, 1'b1);
    checkAllZero("reset_held");

    r_GPTR = 4'b0000;
    w_INC  = 1'b0;
    wRST   = 1'b1;
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    checkAllZero("idle_after_reset");

    // Fill to full
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("fill_addr_pre%0d", i), 32'(w_ADDR), 32'(i));
      applyStimulus(1'b1, 1'b0);
      checkOutput($sformatf("fill_level%0d", i), 32'(w_LEVEL), 32'(i + 1));
      checkOutput($sformatf("fill_gptr%0d", i), 32'(w_GPTR), 32'(gray(4'(i + 1))));
      checkOutput($sformatf("fill_af%0d", i), 32'(w_ALMOST_FULL), 32'((i + 1) >= 6));
      checkOutput($sformatf("fill_full%0d", i), 32'(w_FULL), 32'(i == 7));
    end
    checkOutput("full_gptr", 32'(w_GPTR), 32'(4'b1100));
    checkOutput("full_addr", 32'(w_ADDR), 0);

    // Overflow set / clear / simultaneous
    applyStimulus(1'b1, 1'b0);
    checkOutput("ovf_set", 32'(w_OVF), 1);
    checkOutput("ovf_gptr_hold", 32'(w_GPTR), 32'(4'b1100));
    checkOutput("ovf_addr_hold", 32'(w_ADDR), 0);
    checkOutput("ovf_level_hold", 32'(w_LEVEL), 8);
    applyStimulus(1'b0, 1'b1);
    checkOutput("ovf_clr", 32'(w_OVF), 0);
    applyStimulus(1'b1, 1'b1);
    checkOutput("ovf_set_wins", 32'(w_OVF), 1);
    applyStimulus(1'b0, 1'b1);
    checkOutput("ovf_clr2", 32'(w_OVF), 0);
    w_OVF_CLR = 1'b0;

    // Release: one read seen through the synchronizer
    r_GPTR = 4'b0001;
    applyStimulus(1'b0, 1'b0);
    checkOutput("rel_e1_level", 32'(w_LEVEL), 8);
    checkOutput("rel_e1_full", 32'(w_FULL), 1);
    applyStimulus(1'b0, 1'b0);
    checkOutput("rel_e2_level", 32'(w_LEVEL), 7);
    checkOutput("rel_e2_full", 32'(w_FULL), 1);
    checkOutput("rel_e2_af", 32'(w_ALMOST_FULL), 1);
    applyStimulus(1'b0, 1'b0);
    checkOutput("rel_e3_full", 32'(w_FULL), 0);
    checkOutput("rel_addr", 32'(w_ADDR), 0);
    applyStimulus(1'b1, 1'b0);
    checkOutput("rel_wr_addr", 32'(w_ADDR), 1);
    checkOutput("rel_wr_level", 32'(w_LEVEL), 8);
    checkOutput("rel_wr_full", 32'(w_FULL), 1);

    // Mid-operation reset while full with writes pending
    w_INC = 1'b1;
    wRST  = 1'b0;
    #2;
    checkAllZero("midrst_async");
    applyStimulus(1'b1, 1'b0);
    checkAllZero("midrst_held");
    r_GPTR = 4'b0000;
    wRST   = 1'b1;
    checkOutput("midrst_first_addr", 32'(w_ADDR), 0);
    applyStimulus(1'b1, 1'b0);
    checkOutput("midrst_after_addr", 32'(w_ADDR), 1);
    checkOutput("midrst_after_level", 32'(w_LEVEL), 1);

    // Wrap: 20 writes with the read pointer two behind
    wRST = 1'b0;
    #1;
    wRST     = 1'b1;
    exp_wbin = 4'd0;
    applyStimulus(1'b0, 1'b0);
    prev_gptr = w_GPTR;
    for (int k = 0; k < 20; k++) begin
      r_GPTR = (k >= 2) ? gray(4'(k - 2)) : 4'b0000;
      applyStimulus(1'b1, 1'b0);
      exp_wbin = exp_wbin + 4'd1;
      checkOutput($sformatf("wrap_gptr%0d", k), 32'(w_GPTR), 32'(gray(exp_wbin)));
      checkOutput($sformatf("wrap_onebit%0d", k), 32'($countones(w_GPTR ^ prev_gptr)), 1);
      checkOutput($sformatf("wrap_full%0d", k), 32'(w_FULL), 0);
      checkOutput($sformatf("wrap_addr%0d", k), 32'(w_ADDR), 32'(exp_wbin[2:0]));
      checkOutput($sformatf("wrap_level%0d", k), 32'(w_LEVEL), (k >= 3) ? 32'd4 : 32'(k + 1));
      prev_gptr = w_GPTR;
    end
    checkOutput("wrap_final_gptr", 32'(w_GPTR), 32'(gray(4'd4)));

    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule
